// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - ALU op codes and multiply sequencer state encoding shared with the ALU control decoder
package alu_defs;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ITER  = 3'd1,
        FIX_A = 3'd2,
        FIX_B = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

endpackage

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - multi-cycle MULT/MULTU controller driving a borrowed ALU
module alu_mult_sequencer
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_shamnt,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t      state, state_n;
    logic [WIDTH-1:0] mcand, mplier;
    logic             sgn;
    logic [CW-1:0]    cnt;
    logic             carry;

    // The ALU has no carry-out; an unsigned wrap of hi+addend is detected by the sum being smaller.
    assign carry      = (alu_result < hi);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign alu_shamnt = 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        alu_op  = OPW'(ALU_ADD);
        alu_a   = '0;
        alu_b   = '0;
        case (state)
            IDLE: begin
                if (start) state_n = ITER;
            end
            ITER: begin
                alu_a = hi;
                alu_b = lo[0] ? mcand : '0;
                if (cnt == CW'(WIDTH - 1)) state_n = FIX_A;
            end
            // Signed fix-up: subtract the two's-complement sign corrections from the upper half.
            FIX_A: begin
                alu_op  = OPW'(ALU_SUB);
                alu_a   = hi;
                alu_b   = (sgn & mcand[WIDTH-1]) ? mplier : '0;
                state_n = FIX_B;
            end
            FIX_B: begin
                alu_op  = OPW'(ALU_SUB);
                alu_a   = hi;
                alu_b   = (sgn & mplier[WIDTH-1]) ? mcand : '0;
                state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            sgn    <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        sgn    <= is_signed;
                        cnt    <= '0;
                        hi     <= '0;
                        lo     <= op_b;
                    end
                end
                ITER: begin
                    {hi, lo} <= {carry, alu_result, lo[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                end
                FIX_A, FIX_B: hi <= alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - directed self-checking bench for alu_mult_sequencer
module tb_alu_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamnt;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Reference ALU: only ADD and SUB are exercised by the sequencer.
    assign alu_result = (alu_op == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

    alu_mult_sequencer #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamnt(alu_shamnt), .alu_op(alu_op),
        .alu_result(alu_result)
    );

    // Issues one start pulse at the next negedge and counts cycles until done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; is_signed = s;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) busy_cnt++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
        end
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_hilo hi=%h lo=%h required 0 0", hi, lo);
        end
        n_checks++;
        if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'b0000 || alu_shamnt !== 5'd0) begin
            n_fail++; $display("FAIL reset_alu a=%h b=%h op=%h sh=%h required 0 0 0 0", alu_a, alu_b, alu_op, alu_shamnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_small();
        int cyc, bc;
        run_op(32'd3, 32'd5, 1'b0, cyc, bc);
        n_checks++;
        if (cyc !== 35) begin n_fail++; $display("FAIL multu_small_latency got %0d required 35", cyc); end
        n_checks++;
        if (bc !== 35) begin n_fail++; $display("FAIL multu_small_busy got %0d required 35", bc); end
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'hF) begin
            n_fail++; $display("FAIL multu_small_result hi=%h lo=%h required 00000000 0000000f", hi, lo);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'hF) begin
            n_fail++; $display("FAIL multu_small_hold busy=%b done=%b hi=%h lo=%h required 0 0 0 f", busy, done, hi, lo);
        end
        n_checks++;
        if (alu_op !== 4'b0000 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            n_fail++; $display("FAIL idle_alu op=%h a=%h b=%h required 0 0 0", alu_op, alu_a, alu_b);
        end
    endtask

    task automatic test_multu_max();
        int cyc, bc;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, bc);
        n_checks++;
        if (cyc !== 35 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            n_fail++; $display("FAIL multu_max cyc=%0d hi=%h lo=%h required 35 fffffffe 00000001", cyc, hi, lo);
        end
    endtask

    task automatic test_mult_signed();
        int cyc, bc;
        run_op(32'hFFFFFFFE, 32'd3, 1'b1, cyc, bc);
        n_checks++;
        if (cyc !== 35 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL mult_m2x3 cyc=%0d hi=%h lo=%h required 35 ffffffff fffffffa", cyc, hi, lo);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, cyc, bc);
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h1) begin
            n_fail++; $display("FAIL mult_m1xm1 hi=%h lo=%h required 00000000 00000001", hi, lo);
        end
        run_op(32'h80000000, 32'h80000000, 1'b1, cyc, bc);
        n_checks++;
        if (hi !== 32'h40000000 || lo !== 32'h0) begin
            n_fail++; $display("FAIL mult_min_sq hi=%h lo=%h required 40000000 00000000", hi, lo);
        end
    endtask

    task automatic test_ignored_start();
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; op_a = 32'd3; op_b = 32'd5; is_signed = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin start = 1'b1; op_a = 32'd7; op_b = 32'd7; end
            else start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        n_checks++;
        if (cyc !== 35 || hi !== 32'h0 || lo !== 32'd15) begin
            n_fail++; $display("FAIL ignored_start cyc=%0d hi=%h lo=%h required 35 0 f", cyc, hi, lo);
        end
    endtask

    task automatic test_done_coincident();
        int cyc, bc;
        @(negedge clk);
        start = 1'b1; op_a = 32'd2; op_b = 32'd3; is_signed = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
        end
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || lo !== 32'd6) begin
            n_fail++; $display("FAIL done_coincident busy=%b lo=%h required 0 6", busy, lo);
        end
        // Immediate follow-on: start lands in the cycle after DONE of the previous op.
        run_op(32'd4, 32'd5, 1'b0, cyc, bc);
        run_op(32'd6, 32'd7, 1'b0, cyc, bc);
        n_checks++;
        if (cyc !== 35 || bc !== 35 || hi !== 32'h0 || lo !== 32'd42) begin
            n_fail++; $display("FAIL back_to_back cyc=%0d busy=%0d hi=%h lo=%h required 35 35 0 2a", cyc, bc, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bc;
        @(negedge clk);
        start = 1'b1; op_a = 32'd3; op_b = 32'd5; is_signed = 1'b0;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd2, 32'd2, 1'b0, cyc, bc);
        n_checks++;
        if (cyc !== 35 || bc !== 35 || hi !== 32'h0 || lo !== 32'd4) begin
            n_fail++; $display("FAIL after_reset cyc=%0d busy=%0d hi=%h lo=%h required 35 35 0 4", cyc, bc, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu_small();
        test_multu_max();
        test_mult_signed();
        test_ignored_start();
        test_done_coincident();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
